// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer controller: steps a 10-LED bar on millisecond ticks, waits a
// pseudo-random delay, then times the react press as a 4-digit BCD count.
module reaction_timer_ctrl #(
  parameter int unsigned LIGHT_TICKS = 500,
  parameter int unsigned DELAY_SHIFT = 5,
  parameter logic [6:0]  LFSR_SEED   = 7'h01
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic        react,
  output logic [9:0]  led,
  output logic [15:0] bcd,
  output logic        time_valid,
  output logic        false_start,
  output logic        busy
);

  localparam int unsigned DW = 7 + DELAY_SHIFT;
  localparam logic [15:0] LT_LAST = 16'(LIGHT_TICKS - 1);
  localparam logic [DW-1:0] DELAY_ONE = {{(DW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LIGHTS = 3'd1,
    ST_DELAY  = 3'd2,
    ST_TIMING = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t          state_r, state_s;
  logic [15:0]     tick_cnt_r, tick_cnt_s;
  logic [DW-1:0]   delay_cnt_r, delay_cnt_s;
  logic [DW-1:0]   delay_load_s;
  logic [9:0]      led_r, led_s, led_step_s;
  logic [15:0]     bcd_r, bcd_s;
  logic            valid_r, valid_s;
  logic            fs_r, fs_s;
  logic [6:0]      lfsr_r, lfsr_next_s;
  logic            start_q_r, react_q_r;
  logic            start_rise_s, react_rise_s;

  // Saturating 4-digit BCD increment: 9999 is sticky.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v == 16'h9999) begin
      r = v;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
            carry       = 1'b1;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end else begin
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign start_rise_s = start & ~start_q_r;
  assign react_rise_s = react & ~react_q_r;
  // x^7 + x^6 + 1 Fibonacci feedback; maximal length, never reaches zero
  assign lfsr_next_s  = {lfsr_r[5:0], lfsr_r[6] ^ lfsr_r[5]};
  assign delay_load_s = {lfsr_r, {DELAY_SHIFT{1'b0}}};
  assign led_step_s   = {led_r[8:0], 1'b1};

  assign led         = led_r;
  assign bcd         = bcd_r;
  assign time_valid  = valid_r;
  assign false_start = fs_r;

  // Busy flag decoded straight from the state register.
  always_comb begin
    busy = 1'b0;
    case (state_r)
      ST_LIGHTS, ST_DELAY, ST_TIMING: busy = 1'b1;
      default:                        busy = 1'b0;
    endcase
  end

  // Next-state and next-output computation.
  always_comb begin
    state_s     = state_r;
    tick_cnt_s  = tick_cnt_r;
    delay_cnt_s = delay_cnt_r;
    led_s       = led_r;
    bcd_s       = bcd_r;
    valid_s     = valid_r;
    fs_s        = fs_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_rise_s) begin
          state_s    = ST_LIGHTS;
          tick_cnt_s = 16'd0;
          led_s      = 10'h000;
          bcd_s      = 16'h0000;
          valid_s    = 1'b0;
          fs_s       = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ST_LIGHTS: begin
        if (react_rise_s) begin
          state_s = ST_DONE;
          fs_s    = 1'b1;
          led_s   = 10'h000;
          bcd_s   = 16'h0000;
          valid_s = 1'b0;
        end else if (tick) begin
          if (tick_cnt_r == LT_LAST) begin
            tick_cnt_s = 16'd0;
            led_s      = led_step_s;
            if (led_step_s == 10'h3FF) begin
              state_s     = ST_DELAY;
              delay_cnt_s = delay_load_s;
            end else begin
              state_s = ST_LIGHTS;
            end
          end else begin
            tick_cnt_s = tick_cnt_r + 16'd1;
          end
        end else begin
          tick_cnt_s = tick_cnt_r;
        end
      end
      ST_DELAY: begin
        if (react_rise_s) begin
          state_s = ST_DONE;
          fs_s    = 1'b1;
          led_s   = 10'h000;
          bcd_s   = 16'h0000;
          valid_s = 1'b0;
        end else if (tick) begin
          if (delay_cnt_r == DELAY_ONE) begin
            state_s = ST_TIMING;
            led_s   = 10'h000;
            bcd_s   = 16'h0000;
          end else begin
            delay_cnt_s = delay_cnt_r - DELAY_ONE;
          end
        end else begin
          delay_cnt_s = delay_cnt_r;
        end
      end
      ST_TIMING: begin
        // a react edge beats a coincident tick
        if (react_rise_s) begin
          state_s = ST_DONE;
          valid_s = 1'b1;
        end else if (tick) begin
          bcd_s = bcd_inc(bcd_r);
        end else begin
          bcd_s = bcd_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath, LFSR and edge-detect registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      tick_cnt_r  <= 16'd0;
      delay_cnt_r <= {DW{1'b0}};
      led_r       <= 10'h000;
      bcd_r       <= 16'h0000;
      valid_r     <= 1'b0;
      fs_r        <= 1'b0;
      lfsr_r      <= LFSR_SEED;
      start_q_r   <= 1'b0;
      react_q_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      tick_cnt_r  <= tick_cnt_s;
      delay_cnt_r <= delay_cnt_s;
      led_r       <= led_s;
      bcd_r       <= bcd_s;
      valid_r     <= valid_s;
      fs_r        <= fs_s;
      lfsr_r      <= lfsr_next_s;
      start_q_r   <= start;
      react_q_r   <= react;
    end
  end

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Self-checking bench for reaction_timer_ctrl: directed scenarios plus random
// stimulus, checked every cycle against a count-based behavioural model.
module tb_reaction_timer_ctrl;

  localparam int LT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tick  = 1'b0;
  logic        start = 1'b0;
  logic        react = 1'b0;
  logic [9:0]  led;
  logic [15:0] bcd;
  logic        time_valid, false_start, busy;

  reaction_timer_ctrl #(
    .LIGHT_TICKS(LT),
    .DELAY_SHIFT(5),
    .LFSR_SEED  (7'h01)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick),
    .start      (start),
    .react      (react),
    .led        (led),
    .bcd        (bcd),
    .time_valid (time_valid),
    .false_start(false_start),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model: phase 0 idle, 1 lights, 2 delay, 3 timing, 4 done.
  logic [6:0] lfsr_seq [127];
  int m_phase = 0;
  int m_lit   = 0;   // number of LEDs lit
  int m_ms    = 0;   // measured milliseconds as a plain integer
  int m_sub   = 0;   // ticks counted within the current LED step
  int m_wait  = 0;   // delay ticks remaining
  int m_k     = 0;   // clocks since reset, indexes the LFSR sequence
  bit m_valid = 1'b0;
  bit m_fs    = 1'b0;
  bit m_start_q = 1'b0;
  bit m_react_q = 1'b0;

  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [9:0] to_bar(int n);
    int x;
    x = (1 << n) - 1;
    return x[9:0];
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_enter;
    m_phase = 1; m_sub = 0; m_lit = 0; m_ms = 0; m_valid = 1'b0; m_fs = 1'b0;
  endtask

  task automatic model_false;
    m_phase = 4; m_fs = 1'b1; m_lit = 0; m_ms = 0; m_valid = 1'b0;
  endtask

  task automatic model_edge(bit t, bit s, bit r, bit rst);
    bit sr, rr;
    sr = s && !m_start_q;
    rr = r && !m_react_q;
    if (rst) begin
      m_phase = 0; m_lit = 0; m_ms = 0; m_sub = 0; m_wait = 0; m_k = 0;
      m_valid = 1'b0; m_fs = 1'b0; m_start_q = 1'b0; m_react_q = 1'b0;
    end else begin
      case (m_phase)
        0, 4: if (sr) model_enter();
        1: begin
          if (rr) model_false();
          else if (t) begin
            m_sub++;
            if (m_sub == LT) begin
              m_sub = 0;
              m_lit++;
              if (m_lit == 10) begin
                m_phase = 2;
                m_wait  = int'(lfsr_seq[m_k]) * 32;
              end
            end
          end
        end
        2: begin
          if (rr) model_false();
          else if (t) begin
            if (m_wait == 1) begin m_phase = 3; m_lit = 0; m_ms = 0; end
            else m_wait--;
          end
        end
        3: begin
          if (rr) begin m_phase = 4; m_valid = 1'b1; end
          else if (t) m_ms = (m_ms + 1 > 9999) ? 9999 : m_ms + 1;
        end
        default: m_phase = 0;
      endcase
      m_k = (m_k + 1) % 127;
      m_start_q = s;
      m_react_q = r;
    end
  endtask

  task automatic step(bit t, bit s, bit r, bit rst = 1'b0);
    tick = t; start = s; react = r; reset = rst;
    @(posedge clock);
    model_edge(t, s, r, rst);
    @(negedge clock);
  endtask

  // Compare every observable output against the model once per cycle.
  always @(negedge clock) begin
    if (chk_en) begin
      check("led",         32'(led),         32'(to_bar(m_lit)));
      check("bcd",         32'(bcd),         32'(to_bcd(m_ms)));
      check("time_valid",  32'(time_valid),  32'(m_valid));
      check("false_start", 32'(false_start), 32'(m_fs));
      check("busy",        32'(busy),        32'(m_phase >= 1 && m_phase <= 3));
    end
  end

  task automatic wait_timing;
    int n;
    n = 0;
    while (led != 10'h3FF && n < 200) begin step(1'b1, 1'b0, 1'b0); n++; end
    while (!(busy && led == 10'h000) && n < 5200) begin step(1'b1, 1'b0, 1'b0); n++; end
    checks++;
    if (n >= 5200) begin
      errors++;
      $display("FAIL wait_timing: timing phase not reached after %0d ticks", n);
    end
  endtask

  initial begin
    logic [6:0] v;
    bit s_lvl, r_lvl;
    int n;

    v = 7'h01;
    for (int i = 0; i < 127; i++) begin
      lfsr_seq[i] = v;
      v = {v[5:0], v[6] ^ v[5]};
    end
    check("lfsr_seq1", 32'(lfsr_seq[1]), 32'h02);
    check("lfsr_seq6", 32'(lfsr_seq[6]), 32'h41);
    check("lfsr_period", 32'(v), 32'h01);
    check("to_bcd_37", 32'(to_bcd(37)), 32'h0037);
    check("to_bcd_1000", 32'(to_bcd(1000)), 32'h1000);

    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    check("rst_led", 32'(led), 32'h0);
    check("rst_bcd", 32'(bcd), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // LED sequence with a tick every 4 clocks
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 80; i++) begin
      step(i % 4 == 3, 1'b0, 1'b0);
      if (i == 7)  check("led_step1", 32'(led), 32'h001);
      if (i == 15) check("led_step2", 32'(led), 32'h003);
    end
    check("led_full", 32'(led), 32'h3FF);
    check("busy_delay", 32'(busy), 32'h1);

    // 37 ticks of timing, then react
    wait_timing();
    for (int i = 0; i < 37; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("bcd_37", 32'(bcd), 32'h0037);
    check("valid_37", 32'(time_valid), 32'h1);
    check("busy_done", 32'(busy), 32'h0);
    step(1'b0, 1'b0, 1'b0);

    // False start at led == 07F
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    n = 0;
    while (led != 10'h07F && n < 200) begin step(1'b1, 1'b0, 1'b0); n++; end
    check("reach_07f", 32'(led), 32'h07F);
    step(1'b0, 1'b0, 1'b1);
    check("fs_flag", 32'(false_start), 32'h1);
    check("fs_led", 32'(led), 32'h0);
    check("fs_valid", 32'(time_valid), 32'h0);
    step(1'b0, 1'b0, 1'b0);

    // Tick and react in the same cycle at 0041
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    wait_timing();
    n = 0;
    while (bcd != 16'h0041 && n < 100) begin step(1'b1, 1'b0, 1'b0); n++; end
    step(1'b1, 1'b0, 1'b1);
    check("coinc_bcd", 32'(bcd), 32'h0041);
    check("coinc_valid", 32'(time_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0);

    // Start held high for 100 clocks restarts exactly once
    for (int i = 0; i < 100; i++) step(i % 4 == 3, 1'b1, 1'b0);
    check("hold_led", 32'(led), 32'h3FF);
    check("hold_busy", 32'(busy), 32'h1);

    // Reset in DELAY, then a normal start
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check("rst_mid_led", 32'(led), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    step(1'b0, 1'b1, 1'b0);
    check("restart_busy", 32'(busy), 32'h1);
    step(1'b0, 1'b0, 1'b0);

    // Saturation
    wait_timing();
    for (int i = 0; i < 10005; i++) step(1'b1, 1'b0, 1'b0);
    check("sat_bcd", 32'(bcd), 32'h9999);
    step(1'b0, 1'b0, 1'b1);
    check("sat_react_bcd", 32'(bcd), 32'h9999);
    check("sat_react_valid", 32'(time_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0);

    // Random traffic
    s_lvl = 1'b0;
    r_lvl = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 39) == 0) s_lvl = ~s_lvl;
      if ($urandom_range(0, 299) == 0) r_lvl = ~r_lvl;
      step($urandom_range(0, 1) == 1, s_lvl, r_lvl, $urandom_range(0, 2999) == 0);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
